// File: rtl/caf_pkg.sv
// rtl/caf_pkg.sv - shared CAF sweep state encoding and width helper
package caf_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } caf_sweep_state_e;

   localparam int CAF_SWEEP_STATE_BITS = 2;

   // Ceiling log2; returns 0 for n <= 1.
   function automatic int caf_clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/caf_sweep_counter.sv
// rtl/caf_sweep_counter.sv - nested inner/outer counter with wrap and terminal-count flags
module caf_sweep_counter
   import caf_pkg::*;
#(
   parameter int INNER_COUNT = 256,
   parameter int INNER_BITS  = 8,
   parameter int OUTER_COUNT = 257,
   parameter int OUTER_BITS  = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_i,
   input  logic                  en_i,
   output logic [INNER_BITS-1:0] inner_o,
   output logic [OUTER_BITS-1:0] outer_o,
   output logic                  inner_wrap_o,
   output logic                  outer_term_o,
   output logic                  term_o
);

   logic [INNER_BITS-1:0] inner_q, inner_d;
   logic [OUTER_BITS-1:0] outer_q, outer_d;

   assign inner_wrap_o = (inner_q == INNER_BITS'(INNER_COUNT - 1));
   assign outer_term_o = (outer_q == OUTER_BITS'(OUTER_COUNT - 1));
   assign term_o       = inner_wrap_o & outer_term_o;
   assign inner_o      = inner_q;
   assign outer_o      = outer_q;

   // Outer count wraps to zero after its terminal value so a full pass leaves both at zero.
   always_comb begin
      inner_d = inner_q;
      outer_d = outer_q;
      if (clr_i) begin
         inner_d = '0;
         outer_d = '0;
      end else if (en_i) begin
         if (inner_wrap_o) begin
            inner_d = '0;
            outer_d = outer_term_o ? '0 : outer_q + 1'b1;
         end else begin
            inner_d = inner_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inner_q <= '0;
         outer_q <= '0;
      end else begin
         inner_q <= inner_d;
         outer_q <= outer_d;
      end
   end

endmodule

// File: rtl/caf_lag_sweep_ctrl.sv
// rtl/caf_lag_sweep_ctrl.sv - CAF lag sweep sequencer driving capture-buffer read addresses
module caf_lag_sweep_ctrl
   import caf_pkg::*;
#(
   parameter int CAP_INDEX_BITS = 10,
   parameter int REF_LEN        = 256,
   parameter int REF_INDEX_BITS = 8,
   parameter int LAG_COUNT      = 257,
   parameter int LAG_BITS       = 9,
   parameter int GAP_CYCLES     = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      abort,
   output logic                      cap_rvalid,
   output logic [CAP_INDEX_BITS-1:0] cap_raddr,
   input  logic                      cap_rready,
   input  logic                      freq_tready,
   output logic [LAG_BITS-1:0]       tag_lag,
   output logic [REF_INDEX_BITS-1:0] tag_sample,
   output logic                      tag_first,
   output logic                      tag_last,
   output logic                      lag_done,
   output logic                      busy,
   output logic                      done
);

   localparam int GAP_BITS = (GAP_CYCLES > 1) ? caf_clog2(GAP_CYCLES) : 1;

   if (REF_INDEX_BITS < caf_clog2(REF_LEN)) begin : g_chk_ref
      $error("REF_INDEX_BITS too narrow for REF_LEN");
   end
   if (LAG_BITS < caf_clog2(LAG_COUNT)) begin : g_chk_lag
      $error("LAG_BITS too narrow for LAG_COUNT");
   end
   if (CAP_INDEX_BITS < caf_clog2(LAG_COUNT + REF_LEN - 1)) begin : g_chk_cap
      $error("CAP_INDEX_BITS too narrow for swept address range");
   end

   caf_sweep_state_e        state_q, state_d;
   logic [GAP_BITS-1:0]     gap_q, gap_d;
   logic                    lag_done_q, lag_done_d;
   logic                    cnt_clr, cnt_en;
   logic                    accept;
   logic                    in_sweep;
   logic [REF_INDEX_BITS-1:0] sample_cnt;
   logic [LAG_BITS-1:0]     lag_cnt;
   logic                    sample_wrap, lag_term, sweep_term;

   caf_sweep_counter #(
      .INNER_COUNT (REF_LEN),
      .INNER_BITS  (REF_INDEX_BITS),
      .OUTER_COUNT (LAG_COUNT),
      .OUTER_BITS  (LAG_BITS)
   ) u_counter (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (cnt_clr),
      .en_i         (cnt_en),
      .inner_o      (sample_cnt),
      .outer_o      (lag_cnt),
      .inner_wrap_o (sample_wrap),
      .outer_term_o (lag_term),
      .term_o       (sweep_term)
   );

   // abort masks the handshake so a simultaneous accept never advances the counters
   assign accept = (state_q == ST_RUN) & cap_rready & freq_tready & ~abort;

   always_comb begin
      state_d    = state_q;
      gap_d      = gap_q;
      lag_done_d = 1'b0;
      cnt_clr    = 1'b0;
      cnt_en     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_clr = 1'b1;
            if (start) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
               cnt_clr = 1'b1;
            end else if (accept) begin
               cnt_en = 1'b1;
               if (sample_wrap) begin
                  lag_done_d = 1'b1;
                  if (sweep_term) begin
                     state_d = ST_DONE;
                  end else if (GAP_CYCLES > 0) begin
                     state_d = ST_GAP;
                     gap_d   = '0;
                  end
               end
            end
         end
         ST_GAP: begin
            if (abort) begin
               state_d = ST_IDLE;
               cnt_clr = 1'b1;
            end else if (int'(gap_q) + 1 >= GAP_CYCLES) begin
               state_d = ST_RUN;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         gap_q      <= '0;
         lag_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gap_q      <= gap_d;
         lag_done_q <= lag_done_d;
      end
   end

   // Address and tags are forced to zero outside RUN/GAP so IDLE and DONE look like reset.
   assign in_sweep   = (state_q == ST_RUN) | (state_q == ST_GAP);
   assign busy       = in_sweep;
   assign cap_rvalid = (state_q == ST_RUN);
   assign cap_raddr  = in_sweep ? (CAP_INDEX_BITS'(lag_cnt) + CAP_INDEX_BITS'(sample_cnt)) : '0;
   assign tag_lag    = in_sweep ? lag_cnt : '0;
   assign tag_sample = in_sweep ? sample_cnt : '0;
   assign tag_first  = in_sweep & (sample_cnt == '0);
   assign tag_last   = in_sweep & sample_wrap;
   assign lag_done   = lag_done_q;
   assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_caf_lag_sweep_ctrl.sv
// tb/tb_caf_lag_sweep_ctrl.sv - directed checks of caf_lag_sweep_ctrl in two configurations
module tb_caf_lag_sweep_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Config A: REF_LEN=4, LAG_COUNT=3, GAP=2
   logic       start_a = 1'b0, abort_a = 1'b0, rr_a = 1'b1, fr_a = 1'b1;
   logic       rvalid_a, first_a, last_a, lag_done_a, busy_a, done_a;
   logic [2:0] raddr_a;
   logic [1:0] lag_a, smp_a;

   // Config B: REF_LEN=2, LAG_COUNT=2, GAP=0
   logic       start_b = 1'b0, abort_b = 1'b0, rr_b = 1'b1, fr_b = 1'b1;
   logic       rvalid_b, first_b, last_b, lag_done_b, busy_b, done_b;
   logic [1:0] raddr_b;
   logic [0:0] lag_b, smp_b;

   caf_lag_sweep_ctrl #(
      .CAP_INDEX_BITS(3), .REF_LEN(4), .REF_INDEX_BITS(2),
      .LAG_COUNT(3), .LAG_BITS(2), .GAP_CYCLES(2)
   ) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
      .cap_rvalid(rvalid_a), .cap_raddr(raddr_a), .cap_rready(rr_a),
      .freq_tready(fr_a), .tag_lag(lag_a), .tag_sample(smp_a),
      .tag_first(first_a), .tag_last(last_a), .lag_done(lag_done_a),
      .busy(busy_a), .done(done_a)
   );

   caf_lag_sweep_ctrl #(
      .CAP_INDEX_BITS(2), .REF_LEN(2), .REF_INDEX_BITS(1),
      .LAG_COUNT(2), .LAG_BITS(1), .GAP_CYCLES(0)
   ) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
      .cap_rvalid(rvalid_b), .cap_raddr(raddr_b), .cap_rready(rr_b),
      .freq_tready(fr_b), .tag_lag(lag_b), .tag_sample(smp_b),
      .tag_first(first_b), .tag_last(last_b), .lag_done(lag_done_b),
      .busy(busy_b), .done(done_b)
   );

   int errors = 0;
   int checks = 0;
   int sel = 0;

   logic        o_rvalid, o_first, o_last, o_lag_done, o_busy, o_done;
   logic [31:0] o_raddr, o_lag, o_smp;

   always_comb begin
      if (sel == 0) begin
         o_rvalid = rvalid_a; o_raddr = 32'(raddr_a); o_lag = 32'(lag_a); o_smp = 32'(smp_a);
         o_first = first_a; o_last = last_a; o_lag_done = lag_done_a; o_busy = busy_a; o_done = done_a;
      end else begin
         o_rvalid = rvalid_b; o_raddr = 32'(raddr_b); o_lag = 32'(lag_b); o_smp = 32'(smp_b);
         o_first = first_b; o_last = last_b; o_lag_done = lag_done_b; o_busy = busy_b; o_done = done_b;
      end
   end

   int n_acc, lag_done_cnt, done_cnt, done_cyc, last_acc_cyc, hold2, bubbles;
   int acc_addr[32];
   int acc_first[32];
   int acc_last[32];

   int exp_addr_a[12]  = '{0, 1, 2, 3, 1, 2, 3, 4, 2, 3, 4, 5};
   int exp_first_a[12] = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
   int exp_last_a[12]  = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
   int exp_addr_b[4]   = '{0, 1, 1, 2};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_start(input logic v);
      if (sel == 0) start_a = v; else start_b = v;
   endtask

   task automatic set_ready(input logic rr, input logic fr);
      if (sel == 0) begin rr_a = rr; fr_a = fr; end
      else begin rr_b = rr; fr_b = fr; end
   endtask

   // mode 0: readies high; 1: freq_tready low 3 cycles on lag0 addr2; 2: cap_rready low 5 cycles on lag2 addr5
   task automatic run_sweep(input int mode, input int limit);
      int cyc;
      int stall_left;
      logic rr, fr;
      n_acc = 0; lag_done_cnt = 0; done_cnt = 0; done_cyc = -1;
      last_acc_cyc = -1; hold2 = 0; bubbles = 0;
      stall_left = (mode == 1) ? 3 : 5;
      set_start(1'b1);
      tick();
      set_start(1'b0);
      cyc = 1;
      while (cyc < limit && !(done_cyc >= 0 && cyc > done_cyc + 3)) begin
         rr = 1'b1;
         fr = 1'b1;
         if (mode == 1 && o_rvalid && o_raddr == 2 && o_lag == 0 && stall_left > 0) begin
            fr = 1'b0; stall_left--;
         end
         if (mode == 2 && o_rvalid && o_raddr == 5 && o_lag == 2 && stall_left > 0) begin
            rr = 1'b0; stall_left--;
         end
         set_ready(rr, fr);
         if (o_rvalid && o_raddr == 2 && o_lag == 0) hold2++;
         if (o_rvalid && rr && fr && n_acc < 32) begin
            acc_addr[n_acc]  = int'(o_raddr);
            acc_first[n_acc] = int'(o_first);
            acc_last[n_acc]  = int'(o_last);
            n_acc++;
            last_acc_cyc = cyc;
         end
         if (o_busy && !o_rvalid) bubbles++;
         if (o_lag_done) lag_done_cnt++;
         if (o_done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         tick();
         cyc++;
      end
      set_ready(1'b1, 1'b1);
   endtask

   initial begin
      int k;
      int dcount;

      tick();
      tick();
      chk("reset_rvalid", 32'(rvalid_a), 0);
      chk("reset_raddr", 32'(raddr_a), 0);
      chk("reset_tags", {lag_a, smp_a, first_a, last_a}, 0);
      chk("reset_pulses", {lag_done_a, busy_a, done_a}, 0);
      rst = 1'b0;
      tick();

      // Nominal sweep, config A: done counted inclusively from the start cycle = 1+12+4+1
      sel = 0;
      run_sweep(0, 60);
      chk("a_accepts", n_acc, 12);
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("a_addr%0d", i), acc_addr[i], exp_addr_a[i]);
         chk($sformatf("a_first%0d", i), acc_first[i], exp_first_a[i]);
         chk($sformatf("a_last%0d", i), acc_last[i], exp_last_a[i]);
      end
      chk("a_lag_done_cnt", lag_done_cnt, 3);
      chk("a_done_cnt", done_cnt, 1);
      chk("a_done_cycles", done_cyc + 1, 18);

      // freq_tready stall on address 2 of lag 0
      run_sweep(1, 60);
      chk("stall_accepts", n_acc, 12);
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("stall_addr%0d", i), acc_addr[i], exp_addr_a[i]);
      end
      chk("stall_hold2", hold2, 4);
      chk("stall_done_cycles", done_cyc + 1, 21);
      chk("stall_done_cnt", done_cnt, 1);

      // Final-address stall on cap_rready
      run_sweep(2, 60);
      chk("last_accepts", n_acc, 12);
      chk("last_final_addr", acc_addr[11], 5);
      chk("last_done_cnt", done_cnt, 1);
      chk("last_done_after_accept", done_cyc - last_acc_cyc, 1);
      chk("last_done_cycles", done_cyc + 1, 23);

      // Config B: no gap, continuous valid, done inclusive = 1+4+0+1
      sel = 1;
      run_sweep(0, 40);
      chk("b_accepts", n_acc, 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("b_addr%0d", i), acc_addr[i], exp_addr_b[i]);
         chk($sformatf("b_first_last%0d", i), {acc_first[i][0], acc_last[i][0]},
             (i % 2 == 0) ? 32'd2 : 32'd1);
      end
      chk("b_bubbles", bubbles, 0);
      chk("b_done_cycles", done_cyc + 1, 6);
      chk("b_lag_done_cnt", lag_done_cnt, 2);

      // Abort at lag 1, sample 2
      sel = 0;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      k = 0;
      while (!(rvalid_a && lag_a == 2'd1 && smp_a == 2'd2) && k < 50) begin
         tick();
         k++;
      end
      chk("abort_reached", 32'(k < 50), 1);
      chk("abort_point_addr", 32'(raddr_a), 3);
      abort_a = 1'b1;
      tick();
      abort_a = 1'b0;
      chk("abort_rvalid", 32'(rvalid_a), 0);
      chk("abort_busy", 32'(busy_a), 0);
      chk("abort_pulses", {lag_done_a, done_a}, 0);
      dcount = 0;
      for (int i = 0; i < 20; i++) begin
         if (done_a || busy_a) dcount++;
         tick();
      end
      chk("abort_stays_idle", dcount, 0);
      run_sweep(0, 60);
      chk("replay_accepts", n_acc, 12);
      chk("replay_first_addr", acc_addr[0], 0);
      chk("replay_last_addr", acc_addr[11], 5);
      chk("replay_done_cycles", done_cyc + 1, 18);

      // rst while in GAP, with start held during rst
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      k = 0;
      while (!(busy_a && !rvalid_a) && k < 50) begin
         tick();
         k++;
      end
      chk("gap_reached", 32'(k < 50), 1);
      rst = 1'b1;
      start_a = 1'b1;
      tick();
      chk("rst_gap_rvalid_addr", {rvalid_a, raddr_a}, 0);
      chk("rst_gap_tags", {lag_a, smp_a, first_a, last_a}, 0);
      chk("rst_gap_pulses", {lag_done_a, busy_a, done_a}, 0);
      rst = 1'b0;
      start_a = 1'b0;
      tick();
      chk("rst_start_ignored", {busy_a, rvalid_a}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
